inst_block_cache: RTL

Direct-mapped instruction cache serving whole 128-byte blocks to the fetch stage. It accepts a block request carrying the byte PC, answers hits with the full block after one cycle, and raises `miss` while it refills a line word-by-word from the instruction memory port. Fetch consumes word 0 from the top bits of the block and walks downward, so this block's block layout is fixed to that ordering. The block sits between fetch and the backing instruction memory.

---
 rtl/inst_block_cache.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/inst_block_cache.sv
// Direct-mapped instruction cache delivering whole blocks to fetch.
// Misses refill one word per memory ack; word 0 sits in the top bits.
module inst_block_cache #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_WORDS = 32,
  parameter int LINES       = 8,
  parameter int ADDR_W      = 32,
  parameter int BLOCK_SIZE  = WORD_SIZE * BLOCK_WORDS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [ADDR_W-1:0]     req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [BLOCK_SIZE-1:0] resp_block,
  output logic                  miss,
  output logic                  mem_req,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_ack,
  input  logic [WORD_SIZE-1:0]  mem_rdata,
  input  logic                  flush
);

  localparam int OFF_W = $clog2(BLOCK_SIZE / 8);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
  localparam int K_W   = $clog2(BLOCK_WORDS);

  typedef enum logic {IDLE, REFILL} state_e;
  typedef logic [BLOCK_WORDS-1:0][WORD_SIZE-1:0] blk_t;

  state_e            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [ADDR_W-1:0] base_q, base_d;
  blk_t              fill_q, fill_d;
  blk_t              resp_block_q, resp_block_d;
  logic              resp_valid_q, resp_valid_d;
  logic              flushed_q, flushed_d;
  logic [LINES-1:0]  valid_q, valid_d;
  logic              line_we;

  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [BLOCK_SIZE-1:0] data_q [LINES];

  logic [IDX_W-1:0] req_idx, base_idx;
  logic [TAG_W-1:0] req_tag, base_tag;
  logic [K_W-1:0]   widx;
  logic             hit;
  logic             unused_off;

  assign req_idx    = req_addr[OFF_W +: IDX_W];
  assign req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign base_idx   = base_q[OFF_W +: IDX_W];
  assign base_tag   = base_q[ADDR_W-1 -: TAG_W];
  assign unused_off = ^req_addr[OFF_W-1:0];
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign widx       = K_W'(BLOCK_WORDS - 1) - k_q;

  assign req_ready  = (state_q == IDLE);
  assign miss       = (state_q == REFILL);
  assign mem_req    = (state_q == REFILL);
  assign mem_addr   = (state_q == REFILL)
                    ? base_q + ADDR_W'({k_q, 2'b00})
                    : '0;
  assign resp_valid = resp_valid_q;
  assign resp_block = resp_block_q;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    base_d       = base_q;
    fill_d       = fill_q;
    flushed_d    = flushed_q;
    resp_block_d = resp_block_q;
    resp_valid_d = 1'b0;
    valid_d      = valid_q;
    line_we      = 1'b0;
    if (flush) valid_d = '0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (hit) begin
            resp_block_d = data_q[req_idx];
            resp_valid_d = 1'b1;
          end else begin
            base_d    = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            k_d       = '0;
            flushed_d = 1'b0;
            state_d   = REFILL;
          end
        end
      end
      REFILL: begin
        if (flush) flushed_d = 1'b1;
        if (mem_ack) begin
          fill_d[widx] = mem_rdata;
          k_d          = k_q + 1'b1;
          if (k_q == K_W'(BLOCK_WORDS - 1)) begin
            line_we      = 1'b1;
            resp_block_d = fill_d;
            resp_valid_d = 1'b1;
            k_d          = '0;
            state_d      = IDLE;
            // A flush seen at any point of the refill keeps the line invalid
            if (!(flushed_q || flush)) valid_d[base_idx] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      base_q       <= '0;
      fill_q       <= '0;
      flushed_q    <= 1'b0;
      resp_block_q <= '0;
      resp_valid_q <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      base_q       <= base_d;
      fill_q       <= fill_d;
      flushed_q    <= flushed_d;
      resp_block_q <= resp_block_d;
      resp_valid_q <= resp_valid_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      data_q[base_idx] <= fill_d;
      tag_q[base_idx]  <= base_tag;
    end
  end

endmodule
